// File: rtl/sram16_pkg.sv
// rtl/sram16_pkg.sv - shared types and constants for the 16-bit async SRAM controller
package sram16_pkg;

  localparam int CNT_W = 4;

  localparam int WAIT_MIN = 1;
  localparam int WAIT_MAX = 15;
  localparam int TURN_MIN = 0;
  localparam int TURN_MAX = 3;

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_WR_SETUP   = 3'd1;
  localparam logic [2:0] S_WR_PULSE   = 3'd2;
  localparam logic [2:0] S_WR_HOLD    = 3'd3;
  localparam logic [2:0] S_RD_ACCESS  = 3'd4;
  localparam logic [2:0] S_RD_CAPTURE = 3'd5;
  localparam logic [2:0] S_TURN       = 3'd6;

  typedef enum logic [2:0] {
    IDLE       = S_IDLE,
    WR_SETUP   = S_WR_SETUP,
    WR_PULSE   = S_WR_PULSE,
    WR_HOLD    = S_WR_HOLD,
    RD_ACCESS  = S_RD_ACCESS,
    RD_CAPTURE = S_RD_CAPTURE,
    TURN       = S_TURN
  } state_t;

  // A phase of N cycles loads N-1 so the state advances on the zero flag.
  function automatic logic [CNT_W-1:0] cnt_load(input int cycles);
    return (cycles > 0) ? CNT_W'(cycles - 1) : '0;
  endfunction

endpackage

// File: rtl/sram16_ctrl_if.sv
// rtl/sram16_ctrl_if.sv - request/response bus between a fabric master and the SRAM controller
interface sram16_ctrl_if #(
  parameter int ADDR_W = 18
) ();

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [15:0]       req_wdata;
  logic [1:0]        req_wmask;
  logic              rsp_valid;
  logic [15:0]       rsp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wmask,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_wmask,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/sram16_wait_cnt.sv
// rtl/sram16_wait_cnt.sv - loadable down-counter with zero flag for strobe timing
module sram16_wait_cnt
  import sram16_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/sram16_ctrl.sv
// rtl/sram16_ctrl.sv - single-word bus master for a 16-bit async SRAM behind a registered pad cell
module sram16_ctrl
  import sram16_pkg::*;
#(
  parameter int ADDR_W      = 18,
  parameter int WAIT_CYCLES = 2,
  parameter int TURN_CYCLES = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  sram16_ctrl_if.slave      bus,
  output logic [15:0]       io_write,
  output logic              io_write_enable,
  input  logic [15:0]       io_read,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              sram_lb_n,
  output logic              sram_ub_n
);

  if (WAIT_CYCLES < WAIT_MIN || WAIT_CYCLES > WAIT_MAX) begin : g_bad_wait
    $error("sram16_ctrl: WAIT_CYCLES out of range");
  end
  if (TURN_CYCLES < TURN_MIN || TURN_CYCLES > TURN_MAX) begin : g_bad_turn
    $error("sram16_ctrl: TURN_CYCLES out of range");
  end

  localparam logic [CNT_W-1:0] WAIT_LOAD = cnt_load(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] TURN_LOAD = cnt_load(TURN_CYCLES);

  state_t           state;
  logic             accept;
  logic             cnt_ld;
  logic             cnt_dec;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_zero;

  assign accept = (state == IDLE) && bus.req_ready && bus.req_valid;

  // Counter is loaded on the edge that enters a timed phase, so that phase lasts exactly N cycles.
  always_comb begin
    cnt_ld  = 1'b0;
    cnt_dec = 1'b0;
    cnt_val = WAIT_LOAD;
    case (state)
      IDLE:       cnt_ld = accept && !bus.req_write;
      WR_SETUP:   cnt_ld = 1'b1;
      RD_CAPTURE: begin
        cnt_ld  = 1'b1;
        cnt_val = TURN_LOAD;
      end
      WR_PULSE, RD_ACCESS, TURN: cnt_dec = 1'b1;
      default: ;
    endcase
  end

  sram16_wait_cnt u_wait_cnt (
    .clock      (clock),
    .reset_n    (reset_n),
    .load       (cnt_ld),
    .load_value (cnt_val),
    .dec        (cnt_dec),
    .zero       (cnt_zero)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state           <= IDLE;
      bus.req_ready   <= 1'b0;
      bus.rsp_valid   <= 1'b0;
      bus.rsp_rdata   <= '0;
      io_write        <= '0;
      io_write_enable <= 1'b0;
      sram_addr       <= '0;
      sram_ce_n       <= 1'b1;
      sram_oe_n       <= 1'b1;
      sram_we_n       <= 1'b1;
      sram_lb_n       <= 1'b1;
      sram_ub_n       <= 1'b1;
    end else begin
      bus.rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (!bus.req_ready) begin
            bus.req_ready <= 1'b1;
          end else if (accept) begin
            bus.req_ready <= 1'b0;
            sram_addr     <= bus.req_addr;
            sram_ce_n     <= 1'b0;
            if (bus.req_write) begin
              state           <= WR_SETUP;
              io_write        <= bus.req_wdata;
              io_write_enable <= 1'b1;
              sram_lb_n       <= ~bus.req_wmask[0];
              sram_ub_n       <= ~bus.req_wmask[1];
            end else begin
              state     <= RD_ACCESS;
              sram_oe_n <= 1'b0;
              sram_lb_n <= 1'b0;
              sram_ub_n <= 1'b0;
            end
          end
        end
        // Pad registers write data, so WE falls one cycle after the enable to see valid pins.
        WR_SETUP: begin
          state     <= WR_PULSE;
          sram_we_n <= 1'b0;
        end
        WR_PULSE: begin
          if (cnt_zero) begin
            state     <= WR_HOLD;
            sram_we_n <= 1'b1;
          end
        end
        WR_HOLD: begin
          state           <= IDLE;
          bus.req_ready   <= 1'b1;
          io_write_enable <= 1'b0;
          sram_ce_n       <= 1'b1;
          sram_lb_n       <= 1'b1;
          sram_ub_n       <= 1'b1;
        end
        RD_ACCESS: begin
          if (cnt_zero) begin
            state <= RD_CAPTURE;
          end
        end
        // io_read lags the pins by one register, hence the extra capture cycle with strobes held.
        RD_CAPTURE: begin
          bus.rsp_valid <= 1'b1;
          bus.rsp_rdata <= io_read;
          sram_ce_n     <= 1'b1;
          sram_oe_n     <= 1'b1;
          sram_lb_n     <= 1'b1;
          sram_ub_n     <= 1'b1;
          if (TURN_CYCLES == 0) begin
            state         <= IDLE;
            bus.req_ready <= 1'b1;
          end else begin
            state <= TURN;
          end
        end
        TURN: begin
          if (cnt_zero) begin
            state         <= IDLE;
            bus.req_ready <= 1'b1;
          end
        end
        default: begin
          state         <= IDLE;
          bus.req_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram16_ctrl.sv
// tb/tb_sram16_ctrl.sv - randomized self-checking bench for sram16_ctrl with pad and SRAM models
module tb_sram16_ctrl;

  localparam int AW = 18;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset_n;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   last_acc = 0;
  int   rsp_cnt_b = 0;

  always @(posedge clock) cyc++;

  logic          valid = 1'b0;
  logic          wr = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [15:0]   wdata = '0;
  logic [1:0]    wmask = '0;
  logic          sel = 1'b0;

  sram16_ctrl_if #(.ADDR_W(AW)) bus_a ();
  sram16_ctrl_if #(.ADDR_W(AW)) bus_b ();

  assign bus_a.req_valid = valid & ~sel;
  assign bus_a.req_write = wr;
  assign bus_a.req_addr  = addr;
  assign bus_a.req_wdata = wdata;
  assign bus_a.req_wmask = wmask;
  assign bus_b.req_valid = valid & sel;
  assign bus_b.req_write = wr;
  assign bus_b.req_addr  = addr;
  assign bus_b.req_wdata = wdata;
  assign bus_b.req_wmask = wmask;

  logic [15:0]   io_write_a, io_write_b, pins_a, pins_b;
  logic [15:0]   io_read_a = '0, io_read_b = '0, pad_q_a = '0, pad_q_b = '0;
  logic          io_we_a, io_we_b;
  logic          pad_en_a = 1'b0, pad_en_b = 1'b0;
  logic [AW-1:0] sa_a, sa_b;
  logic          ce_a, oe_a, we_a, lb_a, ub_a;
  logic          ce_b, oe_b, we_b, lb_b, ub_b;
  logic [15:0]   mem_a [64];
  logic [15:0]   mem_b [64];

  sram16_ctrl #(.ADDR_W(AW), .WAIT_CYCLES(2), .TURN_CYCLES(1)) dut_a (
    .clock(clock), .reset_n(reset_n), .bus(bus_a),
    .io_write(io_write_a), .io_write_enable(io_we_a), .io_read(io_read_a),
    .sram_addr(sa_a), .sram_ce_n(ce_a), .sram_oe_n(oe_a), .sram_we_n(we_a),
    .sram_lb_n(lb_a), .sram_ub_n(ub_a)
  );

  sram16_ctrl #(.ADDR_W(AW), .WAIT_CYCLES(1), .TURN_CYCLES(0)) dut_b (
    .clock(clock), .reset_n(reset_n), .bus(bus_b),
    .io_write(io_write_b), .io_write_enable(io_we_b), .io_read(io_read_b),
    .sram_addr(sa_b), .sram_ce_n(ce_b), .sram_oe_n(oe_b), .sram_we_n(we_b),
    .sram_lb_n(lb_b), .sram_ub_n(ub_b)
  );

  // Pad cell: registered drive data, drive enable and pin sample; SRAM drives pins while CE&OE low.
  assign pins_a = pad_en_a ? pad_q_a : (!ce_a && !oe_a) ? mem_a[sa_a[5:0]] : 16'h0;
  assign pins_b = pad_en_b ? pad_q_b : (!ce_b && !oe_b) ? mem_b[sa_b[5:0]] : 16'h0;

  always @(posedge clock) begin
    pad_q_a <= io_write_a; pad_en_a <= io_we_a; io_read_a <= pins_a;
    pad_q_b <= io_write_b; pad_en_b <= io_we_b; io_read_b <= pins_b;
    if (!ce_a && !we_a) begin
      if (!lb_a) mem_a[sa_a[5:0]][7:0]  <= pins_a[7:0];
      if (!ub_a) mem_a[sa_a[5:0]][15:8] <= pins_a[15:8];
    end
    if (!ce_b && !we_b) begin
      if (!lb_b) mem_b[sa_b[5:0]][7:0]  <= pins_b[7:0];
      if (!ub_b) mem_b[sa_b[5:0]][15:8] <= pins_b[15:8];
    end
  end

  logic        m_ready, m_rsp, m_ce, m_oe, m_we, m_lb, m_ub, m_en;
  logic [15:0] m_rdata, m_pins;
  assign m_ready = sel ? bus_b.req_ready : bus_a.req_ready;
  assign m_rsp   = sel ? bus_b.rsp_valid : bus_a.rsp_valid;
  assign m_rdata = sel ? bus_b.rsp_rdata : bus_a.rsp_rdata;
  assign m_ce    = sel ? ce_b : ce_a;
  assign m_oe    = sel ? oe_b : oe_a;
  assign m_we    = sel ? we_b : we_a;
  assign m_lb    = sel ? lb_b : lb_a;
  assign m_ub    = sel ? ub_b : ub_a;
  assign m_en    = sel ? io_we_b : io_we_a;
  assign m_pins  = sel ? pins_b : pins_a;

  logic [15:0] ref_mem [int];

  function automatic logic [15:0] ref_rd(input int key);
    return ref_mem.exists(key) ? ref_mem[key] : 16'h0;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clock) begin
    if (reset_n === 1'b1) begin
      check_eq("contend_a", {31'b0, io_we_a & ~oe_a}, 32'd0);
      check_eq("contend_b", {31'b0, io_we_b & ~oe_b}, 32'd0);
    end
    if (bus_b.rsp_valid === 1'b1) rsp_cnt_b++;
  end

  // One request on the selected instance; timing expected from the access rules, data from ref_mem.
  task automatic xact(input logic w, input logic [AW-1:0] a, input logic [15:0] d, input logic [1:0] m);
    int          wc, tr, n, key;
    logic [15:0] expv;
    logic [1:0]  nm;
    wc  = sel ? 1 : 2;
    tr  = sel ? 0 : 1;
    key = (sel ? 32'h100000 : 32'h0) + int'(a);
    nm  = ~m;
    wr = w; addr = a; wdata = d; wmask = m; valid = 1'b1;
    n = 0;
    while (m_ready !== 1'b1) begin
      @(posedge clock); #1;
      n++;
      if (n > 40) begin
        check_eq("accept_timeout", 32'd0, 32'd1);
        valid = 1'b0;
        return;
      end
    end
    @(posedge clock); #1;
    valid = 1'b0;
    last_acc = cyc;
    expv = ref_rd(key);
    if (w) begin
      if (m[0]) expv[7:0]  = d[7:0];
      if (m[1]) expv[15:8] = d[15:8];
      ref_mem[key] = expv;
      for (int k = 1; k <= wc + 3; k++) begin
        if (k > 1) begin @(posedge clock); #1; end
        check_eq("wr_we_n", m_we, (k >= 2 && k <= wc + 1) ? 0 : 1);
        check_eq("wr_ce_n", m_ce, (k <= wc + 2) ? 0 : 1);
        check_eq("wr_en",   m_en, (k <= wc + 2) ? 1 : 0);
        check_eq("wr_oe_n", m_oe, 1);
        check_eq("wr_ready", m_ready, (k == wc + 3) ? 1 : 0);
        check_eq("wr_rsp", m_rsp, 0);
        if (k == 1) check_eq("wr_bytes_n", {m_ub, m_lb}, nm);
        if (k >= 2 && k <= wc + 2) check_eq("wr_pins", m_pins, d);
      end
    end else begin
      for (int k = 1; k <= wc + tr + 2; k++) begin
        if (k > 1) begin @(posedge clock); #1; end
        check_eq("rd_oe_n", m_oe, (k <= wc + 1) ? 0 : 1);
        check_eq("rd_ce_n", m_ce, (k <= wc + 1) ? 0 : 1);
        check_eq("rd_en", m_en, 0);
        check_eq("rd_we_n", m_we, 1);
        check_eq("rd_rsp_valid", m_rsp, (k == wc + 2) ? 1 : 0);
        check_eq("rd_ready", m_ready, (k == wc + tr + 2) ? 1 : 0);
        if (k == 1) check_eq("rd_bytes_n", {m_ub, m_lb}, 0);
        if (k == wc + 2) check_eq("rd_data", m_rdata, expv);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got=running exp=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int n, prev, cnt0;
    for (int i = 0; i < 64; i++) begin mem_a[i] = '0; mem_b[i] = '0; end
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_eq("rst_ready", bus_a.req_ready, 0);
    check_eq("rst_rsp_valid", bus_a.rsp_valid, 0);
    check_eq("rst_rdata", bus_a.rsp_rdata, 0);
    check_eq("rst_en", io_we_a, 0);
    check_eq("rst_io_write", io_write_a, 0);
    check_eq("rst_addr", sa_a, 0);
    check_eq("rst_strobes", {ce_a, oe_a, we_a, lb_a, ub_a}, 5'h1F);
    reset_n = 1'b1;
    @(posedge clock); #1;
    check_eq("rel_ready_a", bus_a.req_ready, 1);
    check_eq("rel_ready_b", bus_b.req_ready, 1);

    sel = 1'b0;
    xact(1'b1, 18'h00123, 16'hBEEF, 2'b11);
    xact(1'b0, 18'h00123, 16'h0, 2'b00);
    xact(1'b1, 18'h00123, 16'h12AB, 2'b10);
    xact(1'b0, 18'h00123, 16'h0, 2'b00);
    check_eq("byte_merge_ref", ref_rd(32'h123), 16'h12EF);
    xact(1'b1, 18'h00005, 16'h7777, 2'b00);
    xact(1'b0, 18'h00005, 16'h0, 2'b00);

    // Reset in the middle of the write pulse.
    wr = 1'b1; addr = 18'h00030; wdata = 16'hA5A5; wmask = 2'b11; valid = 1'b1;
    n = 0;
    while (m_ready !== 1'b1 && n < 40) begin @(posedge clock); #1; n++; end
    @(posedge clock); #1;
    valid = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check_eq("mid_we_low", we_a, 0);
    reset_n = 1'b0;
    @(posedge clock); #1;
    check_eq("abort_we_n", we_a, 1);
    check_eq("abort_ce_n", ce_a, 1);
    check_eq("abort_en", io_we_a, 0);
    check_eq("abort_ready", bus_a.req_ready, 0);
    check_eq("abort_rsp", bus_a.rsp_valid, 0);
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    @(posedge clock); #1;
    check_eq("abort_rel_ready", bus_a.req_ready, 1);

    for (int i = 0; i < 30; i++) begin
      xact(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), 16'($urandom), 2'($urandom_range(0, 3)));
    end

    sel = 1'b1;
    for (int i = 0; i < 8; i++) xact(1'b1, AW'(i), 16'($urandom), 2'b11);
    cnt0 = rsp_cnt_b;
    prev = 0;
    for (int i = 0; i < 8; i++) begin
      xact(1'b0, AW'(i), 16'h0, 2'b00);
      if (i > 0) check_eq("b2b_interval", last_acc - prev, 3);
      prev = last_acc;
    end
    @(posedge clock); #1;
    check_eq("b2b_rsp_count", rsp_cnt_b - cnt0, 8);

    for (int i = 0; i < 30; i++) begin
      xact(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), 16'($urandom), 2'($urandom_range(0, 3)));
    end

    repeat (4) @(posedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
